regfile_wb_sequencer: RTL and testbench
=======================================

REGFILE_WB_SEQUENCER -- requirements
Module: regfile_wb_sequencer

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive CPU grants while dbg_req is pending before debug gets priority (legal 1..15).
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port wb_valid, input, 1, CPU write-back request valid.
REQ-005 The block SHALL have port dstE / dstM, input, 4 each, write-back destinations; 4'hF (RNONE) means no write.
REQ-006 The block SHALL have port valE / valM, input, 64 each, write-back data.
REQ-007 The block SHALL have port wb_ready, output, 1, CPU request accepted when wb_valid and wb_ready are both high at a clock edge.
REQ-008 The block SHALL have port dbg_req, input, 1, debug write request, held until dbg_gnt.
REQ-009 The block SHALL have port dbg_addr, input, 4, debug write register.
REQ-010 The block SHALL have port dbg_wdata, input, 64, debug write data.
REQ-011 The block SHALL have port dbg_gnt, output, 1, one-cycle debug grant pulse.
REQ-012 The block SHALL have port rf_we, output, 1, register file write enable.
REQ-013 The block SHALL have port rf_waddr, output, 4, register file write address.
REQ-014 The block SHALL have port rf_wdata, output, 64, register file write data.
REQ-015 The block SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-016 The block SHALL implement states IDLE, WR_E, WR_M and DBG, with all outputs decoded from registered state only.
REQ-017 wb_ready SHALL equal (state==IDLE) and not (dbg_req and starve_cnt==STARVE_LIMIT).
REQ-018 On CPU acceptance the block SHALL latch dstE, dstM, valE and valM.
REQ-019 On CPU acceptance, e_need = dstE!=F and not(dstM!=F and dstE==dstM), and m_need = dstM!=F.
REQ-020 On CPU acceptance the next state SHALL be WR_E if e_need, else WR_M if m_need, else IDLE with no write; dstE==dstM SHALL make M win.
REQ-021 WR_E SHALL drive rf_we=1, rf_waddr=dstE_q and rf_wdata=valE_q, then go to WR_M if m_need, else IDLE.
REQ-022 WR_M SHALL drive rf_we=1, rf_waddr=dstM_q and rf_wdata=valM_q, then go to IDLE.
REQ-023 E write latency SHALL be 1 cycle after the acceptance edge, and the M write SHALL follow in the next cycle (or 1 cycle after acceptance if E is skipped).
REQ-024 In IDLE with only dbg_req high, or dbg_req high and starve_cnt==STARVE_LIMIT, the block SHALL latch dbg_addr and dbg_wdata and go to DBG.
REQ-025 DBG SHALL assert dbg_gnt=1 and rf_we=(dbg_addr_q!=F) with the latched address and data for one cycle, then go to IDLE.
REQ-026 starve_cnt (4 bits) SHALL increment, saturating at STARVE_LIMIT, on each CPU acceptance while dbg_req is high, and SHALL clear on entry to DBG or on any edge with dbg_req low.
REQ-027 Outside WR_E, WR_M and DBG, rf_we SHALL be 0 and rf_waddr/rf_wdata SHALL be 0.
REQ-028 Inputs presented while busy SHALL be ignored; no request SHALL be dropped silently once accepted.

Reset
REQ-029 While reset is high the block SHALL hold state=IDLE, starve_cnt=0, all latches=0, rf_we=0, dbg_gnt=0 and busy=0, and wb_ready SHALL be 1 unless dbg_req forces priority (never, since starve_cnt=0).
REQ-030 A reset asserted mid-sequence SHALL abort immediately, asynchronously, and any pending E/M/debug write SHALL be discarded.

Configuration
REQ-031 With macro REGFILE_DBG_PORT_EN defined, the debug port SHALL be fully functional as specified.
REQ-032 With REGFILE_DBG_PORT_EN undefined, the debug inputs SHALL be ignored, dbg_gnt SHALL be tied 0, DBG and starve_cnt SHALL be absent, and wb_ready SHALL equal (state==IDLE).

Verification
REQ-033 Accept wb_valid with dstE=4, valE=0x10, dstM=F -> rf_we for one cycle at +1 with addr 4, data 0x10, then IDLE.
REQ-034 Accept dstE=4, valE=0x20, dstM=4, valM=0x99 -> only one write at +1, addr 4, data 0x99; no E write.
REQ-035 Accept dstE=3, valE=0xA, dstM=0, valM=0xB -> write r3=0xA at +1, write r0=0xB at +2, and wb_ready low during both.
REQ-036 Hold dbg_req high with STARVE_LIMIT=4 under back-to-back CPU requests -> after 4 CPU acceptances, wb_ready drops and dbg_gnt pulses; with dbg_addr=F, rf_we stays 0.
REQ-037 Assert reset during WR_E of a dual write -> rf_we falls immediately, no WR_M write occurs, and busy=0.
REQ-038 Build without REGFILE_DBG_PORT_EN and hold dbg_req=1 -> dbg_gnt never asserts and CPU writes are unaffected.

Source files
------------

// File: rtl/regfile_wb_sequencer.sv
// regfile_wb_sequencer
//
// Purpose:
//   Turns one CPU write-back request, which carries an E destination and an
//   M destination, into at most two single-port register file writes on
//   consecutive cycles. A debug port can also inject register writes.
//   While the debug port is enabled, a starvation counter makes sure that a
//   pending debug request eventually wins over a continuous stream of CPU
//   requests.
//
// Configuration macro:
//   REGFILE_DBG_PORT_EN - when defined, the debug port is functional.
//                         When undefined, the debug inputs are ignored and
//                         dbg_gnt is tied low.
//
// Parameters:
//   STARVE_LIMIT - number of consecutive CPU grants given while dbg_req is
//                  pending before debug takes priority (legal 1..15).
//
// Ports:
//   clock      in   single clock; all state updates on its rising edge
//   reset      in   asynchronous active-high reset
//   wb_valid   in   CPU write-back request valid
//   dstE/dstM  in   [3:0] write-back destinations, 4'hF (RNONE) = no write
//   valE/valM  in   [63:0] write-back data
//   wb_ready   out  CPU request accepted when wb_valid && wb_ready at an edge
//   dbg_req    in   debug write request, held until dbg_gnt
//   dbg_addr   in   [3:0] debug write register
//   dbg_wdata  in   [63:0] debug write data
//   dbg_gnt    out  one-cycle debug grant pulse
//   rf_we      out  register file write enable
//   rf_waddr   out  [3:0] register file write address
//   rf_wdata   out  [63:0] register file write data
//   busy       out  high whenever the sequencer is not idle

module regfile_wb_sequencer #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [3:0]  dstE,
  input  logic [3:0]  dstM,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  output logic        wb_ready,
  input  logic        dbg_req,
  input  logic [3:0]  dbg_addr,
  input  logic [63:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [63:0] rf_wdata,
  output logic        busy
);

  localparam logic [3:0] RNONE = 4'hF;

`ifdef REGFILE_DBG_PORT_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR_E = 2'd1,
    WR_M = 2'd2,
    DBG  = 2'd3
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR_E = 2'd1,
    WR_M = 2'd2
  } state_t;
`endif

  state_t      state;
  state_t      next_state;

  logic [3:0]  dste_q;
  logic [3:0]  dstm_q;
  logic [63:0] vale_q;
  logic [63:0] valm_q;

  logic        accept;
  logic        e_need;
  logic        m_need;

  // When both destinations name the same register the M value is the
  // architecturally newer one, so the E write is dropped entirely and only
  // the M write is performed.
  assign e_need = (dstE != RNONE) && !((dstM != RNONE) && (dstE == dstM));
  assign m_need = (dstM != RNONE);
  assign accept = wb_valid && wb_ready;
  assign busy   = (state != IDLE);

`ifdef REGFILE_DBG_PORT_EN
  logic [3:0]  starve_cnt;
  logic [3:0]  dbg_addr_q;
  logic [63:0] dbg_wdata_q;
  logic        dbg_go;

  // Debug wins in IDLE either when the CPU is not asking, or when the CPU
  // has been granted STARVE_LIMIT times in a row while debug waited. In the
  // second case wb_ready is already low, so accept and dbg_go never overlap.
  assign wb_ready = (state == IDLE) && !(dbg_req && (starve_cnt == LIMIT));
  assign dbg_go   = (state == IDLE) && dbg_req &&
                    (!wb_valid || (starve_cnt == LIMIT));

  // Starvation counter: counts CPU acceptances while debug waits, saturates
  // at the limit, and restarts whenever debug gets served or withdraws.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (!dbg_req || dbg_go) begin
      starve_cnt <= 4'd0;
    end else if (accept && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Debug request capture: the address and data are held while the single
  // DBG cycle drives the register file.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dbg_addr_q  <= 4'd0;
      dbg_wdata_q <= 64'd0;
    end else if (dbg_go) begin
      dbg_addr_q  <= dbg_addr;
      dbg_wdata_q <= dbg_wdata;
    end
  end
`else
  logic unused_dbg_inputs;

  // Without the debug port the debug inputs have no effect at all; they are
  // reduced into one named-unused signal so the port list stays identical.
  assign unused_dbg_inputs = ^{dbg_req, dbg_addr, dbg_wdata};
  assign wb_ready          = (state == IDLE);
  assign dbg_gnt           = 1'b0;
`endif

  // State register. Reset abandons any write still in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // CPU request capture: both destinations and both values are latched on
  // acceptance so the CPU is free to change its inputs during WR_E/WR_M.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dste_q <= 4'd0;
      dstm_q <= 4'd0;
      vale_q <= 64'd0;
      valm_q <= 64'd0;
    end else if (accept) begin
      dste_q <= dstE;
      dstm_q <= dstM;
      vale_q <= valE;
      valm_q <= valM;
    end
  end

  // Next-state logic. From WR_E the M write is still owed only if the
  // latched M destination is a real register; the same-register case never
  // reaches WR_E, so it needs no check here.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (e_need) begin
            next_state = WR_E;
          end else if (m_need) begin
            next_state = WR_M;
          end else begin
            next_state = IDLE;
          end
        end
`ifdef REGFILE_DBG_PORT_EN
        else if (dbg_go) begin
          next_state = DBG;
        end
`endif
      end
      WR_E: begin
        next_state = (dstm_q != RNONE) ? WR_M : IDLE;
      end
      WR_M: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Register file port decode. Outputs depend only on the registered state
  // and latched request, never on the live inputs, and are all zero when
  // no write cycle is in progress.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 4'd0;
    rf_wdata = 64'd0;
`ifdef REGFILE_DBG_PORT_EN
    dbg_gnt  = 1'b0;
`endif
    case (state)
      WR_E: begin
        rf_we    = 1'b1;
        rf_waddr = dste_q;
        rf_wdata = vale_q;
      end
      WR_M: begin
        rf_we    = 1'b1;
        rf_waddr = dstm_q;
        rf_wdata = valm_q;
      end
`ifdef REGFILE_DBG_PORT_EN
      DBG: begin
        dbg_gnt  = 1'b1;
        rf_we    = (dbg_addr_q != RNONE);
        rf_waddr = dbg_addr_q;
        rf_wdata = dbg_wdata_q;
      end
`endif
      default: begin
        rf_we    = 1'b0;
        rf_waddr = 4'd0;
        rf_wdata = 64'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// tb_regfile_wb_sequencer
//
// Purpose:
//   Directed bench for regfile_wb_sequencer. Drives CPU write-back requests,
//   a mid-sequence reset and debug requests, and compares the register file
//   port, handshake and status outputs with hand-computed values.
//
// Configuration macro:
//   REGFILE_DBG_PORT_EN - selects the debug-priority scenario when defined,
//                         otherwise the debug-ignored scenario.

module tb_regfile_wb_sequencer;

  localparam logic [3:0] RNONE = 4'hF;

  logic        clock;
  logic        reset;
  logic        wb_valid;
  logic [3:0]  dstE;
  logic [3:0]  dstM;
  logic [63:0] valE;
  logic [63:0] valM;
  logic        wb_ready;
  logic        dbg_req;
  logic [3:0]  dbg_addr;
  logic [63:0] dbg_wdata;
  logic        dbg_gnt;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        busy;

  int compared;
  int mismatched;

  regfile_wb_sequencer #(
    .STARVE_LIMIT(4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .wb_valid (wb_valid),
    .dstE     (dstE),
    .dstM     (dstM),
    .valE     (valE),
    .valM     (valM),
    .wb_ready (wb_ready),
    .dbg_req  (dbg_req),
    .dbg_addr (dbg_addr),
    .dbg_wdata(dbg_wdata),
    .dbg_gnt  (dbg_gnt),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .busy     (busy)
  );

  // Free-running 10-time-unit clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one CPU request pattern onto the inputs.
  task automatic applyStimulus(input logic v, input logic [3:0] de,
                               input logic [63:0] ve, input logic [3:0] dm,
                               input logic [63:0] vm);
    wb_valid = v;
    dstE     = de;
    valE     = ve;
    dstM     = dm;
    valM     = vm;
  endtask

  // Advance to one time unit after the next rising edge.
  task automatic stepClock();
    @(posedge clock);
    #1;
  endtask

  // Compare one observed value with its expected value.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed,
             expected);
    end
  endtask

  // Check the full register file port in one call.
  task automatic checkWrite(input string tag, input logic we,
                            input logic [3:0] addr, input logic [63:0] data);
    checkOutput({tag, "_we"}, 64'(rf_we), 64'(we));
    checkOutput({tag, "_addr"}, 64'(rf_waddr), 64'(addr));
    checkOutput({tag, "_data"}, rf_wdata, data);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    dbg_req    = 1'b0;
    dbg_addr   = 4'd0;
    dbg_wdata  = 64'd0;
    applyStimulus(1'b0, RNONE, 64'd0, RNONE, 64'd0);

    $display("[TB] reset state");
    stepClock();
    checkWrite("rst", 1'b0, 4'd0, 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_ready", 64'(wb_ready), 64'd1);
    checkOutput("rst_gnt", 64'(dbg_gnt), 64'd0);
    reset = 1'b0;
    stepClock();

    $display("[TB] E-only write");
    applyStimulus(1'b1, 4'd4, 64'h10, RNONE, 64'd0);
    checkOutput("eonly_ready_pre", 64'(wb_ready), 64'd1);
    stepClock();
    applyStimulus(1'b0, RNONE, 64'd0, RNONE, 64'd0);
    checkWrite("eonly_w1", 1'b1, 4'd4, 64'h10);
    checkOutput("eonly_busy", 64'(busy), 64'd1);
    checkOutput("eonly_ready_busy", 64'(wb_ready), 64'd0);
    stepClock();
    checkWrite("eonly_after", 1'b0, 4'd0, 64'd0);
    checkOutput("eonly_idle", 64'(busy), 64'd0);

    $display("[TB] same destination, M wins");
    applyStimulus(1'b1, 4'd4, 64'h20, 4'd4, 64'h99);
    stepClock();
    applyStimulus(1'b0, RNONE, 64'd0, RNONE, 64'd0);
    checkWrite("same_w1", 1'b1, 4'd4, 64'h99);
    stepClock();
    checkWrite("same_after", 1'b0, 4'd0, 64'd0);
    checkOutput("same_idle", 64'(busy), 64'd0);

    $display("[TB] dual write");
    applyStimulus(1'b1, 4'd3, 64'hA, 4'd0, 64'hB);
    stepClock();
    applyStimulus(1'b0, RNONE, 64'd0, RNONE, 64'd0);
    checkWrite("dual_e", 1'b1, 4'd3, 64'hA);
    checkOutput("dual_ready_e", 64'(wb_ready), 64'd0);
    stepClock();
    checkWrite("dual_m", 1'b1, 4'd0, 64'hB);
    checkOutput("dual_ready_m", 64'(wb_ready), 64'd0);
    stepClock();
    checkWrite("dual_after", 1'b0, 4'd0, 64'd0);
    checkOutput("dual_ready_after", 64'(wb_ready), 64'd1);

    $display("[TB] no-write request");
    applyStimulus(1'b1, RNONE, 64'h77, RNONE, 64'h88);
    stepClock();
    applyStimulus(1'b0, RNONE, 64'd0, RNONE, 64'd0);
    checkWrite("none", 1'b0, 4'd0, 64'd0);
    checkOutput("none_busy", 64'(busy), 64'd0);

    $display("[TB] inputs ignored while busy");
    applyStimulus(1'b1, 4'd5, 64'h55, 4'd6, 64'h66);
    stepClock();
    applyStimulus(1'b1, 4'd7, 64'h77, RNONE, 64'd0);
    checkWrite("ign_e", 1'b1, 4'd5, 64'h55);
    stepClock();
    checkWrite("ign_m", 1'b1, 4'd6, 64'h66);
    stepClock();
    applyStimulus(1'b0, RNONE, 64'd0, RNONE, 64'd0);
    checkWrite("ign_after", 1'b0, 4'd0, 64'd0);
    checkOutput("ign_busy", 64'(busy), 64'd0);
    stepClock();
    checkWrite("ign_after2", 1'b0, 4'd0, 64'd0);

    $display("[TB] reset during WR_E");
    applyStimulus(1'b1, 4'd1, 64'h11, 4'd2, 64'h22);
    stepClock();
    applyStimulus(1'b0, RNONE, 64'd0, RNONE, 64'd0);
    checkWrite("rstmid_e", 1'b1, 4'd1, 64'h11);
    #2;
    reset = 1'b1;
    #1;
    checkWrite("rstmid_async", 1'b0, 4'd0, 64'd0);
    checkOutput("rstmid_busy", 64'(busy), 64'd0);
    stepClock();
    reset = 1'b0;
    stepClock();
    checkWrite("rstmid_no_m", 1'b0, 4'd0, 64'd0);
    checkOutput("rstmid_idle", 64'(busy), 64'd0);
    applyStimulus(1'b1, 4'd2, 64'h5A, RNONE, 64'd0);
    stepClock();
    applyStimulus(1'b0, RNONE, 64'd0, RNONE, 64'd0);
    checkWrite("rstmid_recover", 1'b1, 4'd2, 64'h5A);
    stepClock();

`ifdef REGFILE_DBG_PORT_EN
    $display("[TB] debug starvation priority");
    dbg_req   = 1'b1;
    dbg_addr  = RNONE;
    dbg_wdata = 64'hDEAD;
    applyStimulus(1'b1, RNONE, 64'd0, RNONE, 64'd0);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("starve_ready_%0d", k), 64'(wb_ready), 64'd1);
      stepClock();
      checkOutput($sformatf("starve_gnt_%0d", k), 64'(dbg_gnt), 64'd0);
    end
    checkOutput("starve_ready_drop", 64'(wb_ready), 64'd0);
    stepClock();
    dbg_req = 1'b0;
    applyStimulus(1'b0, RNONE, 64'd0, RNONE, 64'd0);
    checkOutput("starve_gnt", 64'(dbg_gnt), 64'd1);
    checkOutput("starve_we_none", 64'(rf_we), 64'd0);
    checkOutput("starve_busy", 64'(busy), 64'd1);
    stepClock();
    checkOutput("starve_gnt_end", 64'(dbg_gnt), 64'd0);
    checkOutput("starve_idle", 64'(busy), 64'd0);

    $display("[TB] debug write with idle CPU");
    dbg_req   = 1'b1;
    dbg_addr  = 4'd9;
    dbg_wdata = 64'hCAFE;
    stepClock();
    dbg_req = 1'b0;
    checkOutput("dbgw_gnt", 64'(dbg_gnt), 64'd1);
    checkWrite("dbgw", 1'b1, 4'd9, 64'hCAFE);
    stepClock();
    checkWrite("dbgw_after", 1'b0, 4'd0, 64'd0);
    checkOutput("dbgw_gnt_end", 64'(dbg_gnt), 64'd0);
`else
    $display("[TB] debug port disabled");
    dbg_req   = 1'b1;
    dbg_addr  = 4'd9;
    dbg_wdata = 64'hCAFE;
    stepClock();
    checkOutput("nodbg_idle_gnt", 64'(dbg_gnt), 64'd0);
    checkOutput("nodbg_idle_busy", 64'(busy), 64'd0);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 4'(k), 64'(k * 3 + 1), RNONE, 64'd0);
      checkOutput($sformatf("nodbg_ready_%0d", k), 64'(wb_ready), 64'd1);
      stepClock();
      applyStimulus(1'b0, RNONE, 64'd0, RNONE, 64'd0);
      checkWrite($sformatf("nodbg_w%0d", k), 1'b1, 4'(k), 64'(k * 3 + 1));
      checkOutput($sformatf("nodbg_gnt_%0d", k), 64'(dbg_gnt), 64'd0);
      stepClock();
      checkOutput($sformatf("nodbg_gnt_idle_%0d", k), 64'(dbg_gnt), 64'd0);
    end
    dbg_req = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared,
             mismatched);
    $finish;
  end

endmodule
